// File: rtl/maxpool2d.sv
// maxpool2d -- 2-D max pooling engine over a multi-channel feature map.
//
// Reads each POOLxPOOL window of every channel from a synchronous conv buffer,
// one sample per READ/CMP pair. It keeps a signed running maximum and writes
// one pooled value per window to the pool buffer. A single output pixel costs
// 2*POOL*POOL+1 cycles.
//
// Optional feature: define MAXPOOL_RELU_EN to clamp negative maxima to zero
// on the way to pool_d.
//
// Ports:
//   clk         single clock, rising edge
//   reset_n     asynchronous active-low reset
//   start       one-cycle pass request, only honoured in IDLE
//   conv_addr   conv buffer read address (0 unless reading)
//   conv_en     conv buffer read enable; data returns on conv_q one cycle later
//   conv_q      conv buffer read data (signed)
//   pool_addr   pool buffer write address (0 unless writing)
//   pool_en     pool buffer enable  (high only in WRITE)
//   pool_we     pool buffer write strobe (high only in WRITE)
//   pool_d      pool buffer write data (0 unless writing)
//   busy        high whenever the FSM is not IDLE
//   done        one-cycle completion pulse (FINISH state)
//   o_dbg_state current FSM state, for observation only
//
// Handshake: there is no backpressure. conv_en is a fire-and-forget read
// request. The read data is consumed unconditionally in the following cycle.
// pool_we is a fire-and-forget write.
module maxpool2d #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IMG_SIZE   = 28,
  parameter int POOL       = 2,
  localparam int OUT       = IMG_SIZE / POOL,
  localparam int CONV_AW   = (CHANNELS*IMG_SIZE*IMG_SIZE > 1) ? $clog2(CHANNELS*IMG_SIZE*IMG_SIZE) : 1,
  localparam int POOL_AW   = (CHANNELS*OUT*OUT > 1) ? $clog2(CHANNELS*OUT*OUT) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  output logic [CONV_AW-1:0]           conv_addr,
  output logic                         conv_en,
  input  logic signed [DATA_WIDTH-1:0] conv_q,
  output logic [POOL_AW-1:0]           pool_addr,
  output logic                         pool_en,
  output logic                         pool_we,
  output logic signed [DATA_WIDTH-1:0] pool_d,
  output logic                         busy,
  output logic                         done,
  output logic [2:0]                   o_dbg_state
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OW = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int KW = (POOL > 1) ? $clog2(POOL) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_CMP    = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]                   r_state;
  logic [CW-1:0]                r_c;
  logic [OW-1:0]                r_orow;
  logic [OW-1:0]                r_ocol;
  logic [KW-1:0]                r_kr;
  logic [KW-1:0]                r_kc;
  logic signed [DATA_WIDTH-1:0] r_max;

  logic                         w_last_kc;
  logic                         w_last_kr;
  logic                         w_last_ocol;
  logic                         w_last_orow;
  logic                         w_last_c;
  logic signed [DATA_WIDTH-1:0] w_pool_val;

  assign w_last_kc   = (r_kc   == KW'(POOL - 1));
  assign w_last_kr   = (r_kr   == KW'(POOL - 1));
  assign w_last_ocol = (r_ocol == OW'(OUT - 1));
  assign w_last_orow = (r_orow == OW'(OUT - 1));
  assign w_last_c    = (r_c    == CW'(CHANNELS - 1));

`ifdef MAXPOOL_RELU_EN
  assign w_pool_val = r_max[DATA_WIDTH-1] ? '0 : r_max;
`else
  assign w_pool_val = r_max;
`endif

  // Outputs decode straight from the registered state, so an asynchronous
  // reset drops every strobe and bus to zero in the same cycle.
  assign conv_en     = (r_state == S_READ);
  assign pool_en     = (r_state == S_WRITE);
  assign pool_we     = (r_state == S_WRITE);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FINISH);
  assign o_dbg_state = r_state;

  // Window origin is (orow*POOL, ocol*POOL); a trailing odd row/column is
  // never reached because orow/ocol stop at OUT-1.
  assign conv_addr = (r_state == S_READ) ?
    CONV_AW'(((32'(r_c) * 32'(IMG_SIZE) + 32'(r_orow) * 32'(POOL) + 32'(r_kr)) * 32'(IMG_SIZE))
             + 32'(r_ocol) * 32'(POOL) + 32'(r_kc)) : '0;

  assign pool_addr = (r_state == S_WRITE) ?
    POOL_AW'((32'(r_c) * 32'(OUT) + 32'(r_orow)) * 32'(OUT) + 32'(r_ocol)) : '0;

  assign pool_d = (r_state == S_WRITE) ? w_pool_val : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_orow  <= '0;
      r_ocol  <= '0;
      r_kr    <= '0;
      r_kc    <= '0;
      r_max   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_c     <= '0;
            r_orow  <= '0;
            r_ocol  <= '0;
            r_kr    <= '0;
            r_kc    <= '0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_state <= S_CMP;
        end
        S_CMP: begin
          // First sample of a window seeds the max; later ones compete.
          if ((r_kr == '0) && (r_kc == '0)) begin
            r_max <= conv_q;
          end else if (conv_q > r_max) begin
            r_max <= conv_q;
          end
          if (w_last_kc) begin
            r_kc <= '0;
            if (w_last_kr) begin
              r_kr    <= '0;
              r_state <= S_WRITE;
            end else begin
              r_kr    <= r_kr + KW'(1);
              r_state <= S_READ;
            end
          end else begin
            r_kc    <= r_kc + KW'(1);
            r_state <= S_READ;
          end
        end
        S_WRITE: begin
          if (w_last_ocol) begin
            r_ocol <= '0;
            if (w_last_orow) begin
              r_orow <= '0;
              r_c    <= w_last_c ? '0 : r_c + CW'(1);
            end else begin
              r_orow <= r_orow + OW'(1);
            end
          end else begin
            r_ocol <= r_ocol + OW'(1);
          end
          r_state <= (w_last_ocol && w_last_orow && w_last_c) ? S_FINISH : S_READ;
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool2d.sv
// Testbench for maxpool2d. Four instances cover the configurations below:
//   a : CHANNELS=1, IMG_SIZE=4, conv[i]=i
//   b : CHANNELS=2, IMG_SIZE=4, all -3, or mixed-sign data
//   d : default parameters (timing and write count)
//   e : CHANNELS=1, IMG_SIZE=5 (odd size, trailing row/col unused)
module tb_maxpool2d;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- instance a ----------------
  logic        a_start = 1'b0;
  logic [3:0]  a_conv_addr;
  logic        a_conv_en;
  logic [15:0] a_conv_q = '0;
  logic [1:0]  a_pool_addr;
  logic        a_pool_en, a_pool_we;
  logic [15:0] a_pool_d;
  logic        a_busy, a_done;
  logic [2:0]  a_state;

  maxpool2d #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_SIZE(4), .POOL(2)) u_a (
    .clk(clk), .reset_n(reset_n), .start(a_start),
    .conv_addr(a_conv_addr), .conv_en(a_conv_en), .conv_q(a_conv_q),
    .pool_addr(a_pool_addr), .pool_en(a_pool_en), .pool_we(a_pool_we), .pool_d(a_pool_d),
    .busy(a_busy), .done(a_done), .o_dbg_state(a_state));

  // ---------------- instance b ----------------
  logic        b_start = 1'b0;
  logic        b_mode = 1'b0;
  logic [4:0]  b_conv_addr;
  logic        b_conv_en;
  logic [15:0] b_conv_q = '0;
  logic [2:0]  b_pool_addr;
  logic        b_pool_en, b_pool_we;
  logic [15:0] b_pool_d;
  logic        b_busy, b_done;
  logic [2:0]  b_state;

  maxpool2d #(.DATA_WIDTH(16), .CHANNELS(2), .IMG_SIZE(4), .POOL(2)) u_b (
    .clk(clk), .reset_n(reset_n), .start(b_start),
    .conv_addr(b_conv_addr), .conv_en(b_conv_en), .conv_q(b_conv_q),
    .pool_addr(b_pool_addr), .pool_en(b_pool_en), .pool_we(b_pool_we), .pool_d(b_pool_d),
    .busy(b_busy), .done(b_done), .o_dbg_state(b_state));

  // ---------------- instance d (defaults) ----------------
  logic        d_start = 1'b0;
  logic [12:0] d_conv_addr;
  logic        d_conv_en;
  logic [15:0] d_conv_q = '0;
  logic [10:0] d_pool_addr;
  logic        d_pool_en, d_pool_we;
  logic [15:0] d_pool_d;
  logic        d_busy, d_done;
  logic [2:0]  d_state;

  maxpool2d u_d (
    .clk(clk), .reset_n(reset_n), .start(d_start),
    .conv_addr(d_conv_addr), .conv_en(d_conv_en), .conv_q(d_conv_q),
    .pool_addr(d_pool_addr), .pool_en(d_pool_en), .pool_we(d_pool_we), .pool_d(d_pool_d),
    .busy(d_busy), .done(d_done), .o_dbg_state(d_state));

  // ---------------- instance e ----------------
  logic        e_start = 1'b0;
  logic [4:0]  e_conv_addr;
  logic        e_conv_en;
  logic [15:0] e_conv_q = '0;
  logic [1:0]  e_pool_addr;
  logic        e_pool_en, e_pool_we;
  logic [15:0] e_pool_d;
  logic        e_busy, e_done;
  logic [2:0]  e_state;

  maxpool2d #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_SIZE(5), .POOL(2)) u_e (
    .clk(clk), .reset_n(reset_n), .start(e_start),
    .conv_addr(e_conv_addr), .conv_en(e_conv_en), .conv_q(e_conv_q),
    .pool_addr(e_pool_addr), .pool_en(e_pool_en), .pool_we(e_pool_we), .pool_d(e_pool_d),
    .busy(e_busy), .done(e_done), .o_dbg_state(e_state));

  // ---------------- conv buffer models (1-cycle read latency) ----------------
  always @(posedge clk) begin
    if (a_conv_en) a_conv_q <= 16'(a_conv_addr);
    if (b_conv_en) begin
      if (!b_mode) b_conv_q <= 16'hFFFD;
      else         b_conv_q <= b_conv_addr[0] ? (16'd0 - 16'(b_conv_addr)) : 16'(b_conv_addr);
    end
    if (d_conv_en) d_conv_q <= 16'(d_conv_addr) ^ 16'h5A5A;
    if (e_conv_en) e_conv_q <= 16'(e_conv_addr);
  end

  // ---------------- write capture / protocol monitors ----------------
  logic [7:0]  a_wa_q[$];
  logic [15:0] a_wd_q[$];
  logic [7:0]  b_wa_q[$];
  logic [15:0] b_wd_q[$];
  logic [7:0]  e_wa_q[$];
  logic [15:0] e_wd_q[$];
  logic [15:0] exp_q[$];
  int d_wr_cnt = 0;
  int d_seq_err = 0;
  int e_rd_cnt = 0;
  int e_bad = 0;
  int excl_err = 0;

  always @(negedge clk) begin
    if (a_pool_we) begin a_wa_q.push_back(8'(a_pool_addr)); a_wd_q.push_back(a_pool_d); end
    if (b_pool_we) begin b_wa_q.push_back(8'(b_pool_addr)); b_wd_q.push_back(b_pool_d); end
    if (e_pool_we) begin e_wa_q.push_back(8'(e_pool_addr)); e_wd_q.push_back(e_pool_d); end
    if (d_pool_we) begin
      if (d_pool_addr != 11'(d_wr_cnt)) d_seq_err++;
      d_wr_cnt++;
    end
    if (e_conv_en) begin
      e_rd_cnt++;
      if ((e_conv_addr % 5 == 4) || (e_conv_addr >= 5'd20)) e_bad++;
    end
    if ((a_conv_en && a_pool_we) || (a_pool_en !== a_pool_we)) excl_err++;
    if ((b_conv_en && b_pool_we) || (b_pool_en !== b_pool_we)) excl_err++;
    if ((d_conv_en && d_pool_we) || (d_pool_en !== d_pool_we)) excl_err++;
    if ((e_conv_en && e_pool_we) || (e_pool_en !== e_pool_we)) excl_err++;
  end

  // ---------------- driver tasks ----------------
  function automatic logic done_of(input int which);
    case (which)
      0: done_of = a_done;
      1: done_of = b_done;
      2: done_of = d_done;
      default: done_of = e_done;
    endcase
  endfunction

  function automatic logic busy_of(input int which);
    case (which)
      0: busy_of = a_busy;
      1: busy_of = b_busy;
      2: busy_of = d_busy;
      default: busy_of = e_busy;
    endcase
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0: a_start = v;
      1: b_start = v;
      2: d_start = v;
      default: e_start = v;
    endcase
  endtask

  // Pulses start, then counts negedges until done is seen. cyc counts the
  // start-sampling edge as 1. restart_at>0 re-pulses start at that count.
  // cyc = -1 on timeout.
  task automatic run_pass(input int which, input int budget, input int restart_at,
                          output int cyc, output int busy_lo);
    busy_lo = 0;
    cyc = -1;
    @(negedge clk);
    set_start(which, 1'b1);
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (i == 1) set_start(which, 1'b0);
      if (restart_at > 0 && i == restart_at)     set_start(which, 1'b1);
      if (restart_at > 0 && i == restart_at + 1) set_start(which, 1'b0);
      if (!busy_of(which)) busy_lo++;
      if (done_of(which)) begin
        cyc = i;
        break;
      end
    end
    set_start(which, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_cmp++;
    if ({a_conv_en, a_pool_en, a_pool_we, a_busy, a_done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_a_strobes: got %b expected 00000", {a_conv_en, a_pool_en, a_pool_we, a_busy, a_done});
    end
    n_cmp++;
    if ({a_conv_addr, a_pool_addr, a_pool_d} !== 22'b0) begin
      n_fail++; $display("FAIL reset_a_buses: got %h expected 0", {a_conv_addr, a_pool_addr, a_pool_d});
    end
    n_cmp++;
    if ({d_conv_en, d_pool_we, d_busy, d_done, d_conv_addr, d_pool_addr, d_pool_d} !== 44'b0) begin
      n_fail++; $display("FAIL reset_d_outputs: got %h expected 0", {d_conv_en, d_pool_we, d_busy, d_done, d_conv_addr, d_pool_addr, d_pool_d});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({a_busy, b_busy, d_busy, e_busy} !== 4'b0) begin
      n_fail++; $display("FAIL idle_without_start: got %b expected 0000", {a_busy, b_busy, d_busy, e_busy});
    end
  endtask

  task automatic test_pattern_a(input string tag, input int restart_at);
    int cyc, blo;
    a_wa_q.delete(); a_wd_q.delete(); exp_q.delete();
    exp_q.push_back(16'd5); exp_q.push_back(16'd7); exp_q.push_back(16'd13); exp_q.push_back(16'd15);
    run_pass(0, 200, restart_at, cyc, blo);
    n_cmp++;
    if (cyc !== 37) begin n_fail++; $display("FAIL %s_done_cycle: got %0d expected 37", tag, cyc); end
    n_cmp++;
    if (blo !== 0) begin n_fail++; $display("FAIL %s_busy: got %0d idle cycles expected 0", tag, blo); end
    @(negedge clk);
    n_cmp++;
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL %s_done_width: got %b expected 0", tag, a_done); end
    n_cmp++;
    if (a_wa_q.size() !== 4) begin n_fail++; $display("FAIL %s_write_count: got %0d expected 4", tag, a_wa_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= a_wa_q.size()) begin
        n_fail++; $display("FAIL %s_write%0d: missing expected addr %0d data %0d", tag, i, i, exp_q[i]);
      end else if (a_wa_q[i] !== 8'(i) || a_wd_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL %s_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                           tag, i, a_wa_q[i], a_wd_q[i], i, exp_q[i]);
      end
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL %s_back_to_idle: got busy %b expected 0", tag, a_busy); end
  endtask

  task automatic test_b(input string tag, input logic mode);
    int cyc, blo;
    b_mode = mode;
    b_wa_q.delete(); b_wd_q.delete(); exp_q.delete();
    if (!mode) begin
      for (int i = 0; i < 8; i++) begin
`ifdef MAXPOOL_RELU_EN
        exp_q.push_back(16'h0000);
`else
        exp_q.push_back(16'hFFFD);
`endif
      end
    end else begin
      // Even addresses hold +addr, odd hold -addr: max is the window's b+4.
      exp_q.push_back(16'd4);  exp_q.push_back(16'd6);  exp_q.push_back(16'd12); exp_q.push_back(16'd14);
      exp_q.push_back(16'd20); exp_q.push_back(16'd22); exp_q.push_back(16'd28); exp_q.push_back(16'd30);
    end
    run_pass(1, 300, 0, cyc, blo);
    n_cmp++;
    if (cyc !== 73) begin n_fail++; $display("FAIL %s_done_cycle: got %0d expected 73", tag, cyc); end
    @(negedge clk);
    n_cmp++;
    if (b_wa_q.size() !== 8) begin n_fail++; $display("FAIL %s_write_count: got %0d expected 8", tag, b_wa_q.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= b_wa_q.size()) begin
        n_fail++; $display("FAIL %s_write%0d: missing expected data %h", tag, i, exp_q[i]);
      end else if (b_wa_q[i] !== 8'(i) || b_wd_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL %s_write%0d: got addr %0d data %h expected addr %0d data %h",
                           tag, i, b_wa_q[i], b_wd_q[i], i, exp_q[i]);
      end
    end
  endtask

  task automatic test_odd_size();
    int cyc, blo;
    e_wa_q.delete(); e_wd_q.delete(); exp_q.delete();
    e_rd_cnt = 0; e_bad = 0;
    exp_q.push_back(16'd6); exp_q.push_back(16'd8); exp_q.push_back(16'd16); exp_q.push_back(16'd18);
    run_pass(3, 200, 0, cyc, blo);
    n_cmp++;
    if (cyc !== 37) begin n_fail++; $display("FAIL odd_done_cycle: got %0d expected 37", cyc); end
    @(negedge clk);
    n_cmp++;
    if (e_bad !== 0) begin n_fail++; $display("FAIL odd_trailing_addr: got %0d reads of row/col 4 expected 0", e_bad); end
    n_cmp++;
    if (e_rd_cnt !== 16) begin n_fail++; $display("FAIL odd_read_count: got %0d expected 16", e_rd_cnt); end
    n_cmp++;
    if (e_wa_q.size() !== 4) begin n_fail++; $display("FAIL odd_write_count: got %0d expected 4", e_wa_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= e_wa_q.size()) begin
        n_fail++; $display("FAIL odd_write%0d: missing expected data %0d", i, exp_q[i]);
      end else if (e_wa_q[i] !== 8'(i) || e_wd_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL odd_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                           i, e_wa_q[i], e_wd_q[i], i, exp_q[i]);
      end
    end
  endtask

  task automatic test_default_timing();
    int cyc, blo;
    d_wr_cnt = 0; d_seq_err = 0;
    run_pass(2, 20000, 0, cyc, blo);
    n_cmp++;
    if (cyc !== 14113) begin n_fail++; $display("FAIL default_done_cycle: got %0d expected 14113", cyc); end
    n_cmp++;
    if (blo !== 0) begin n_fail++; $display("FAIL default_busy: got %0d idle cycles expected 0", blo); end
    @(negedge clk);
    n_cmp++;
    if (d_done !== 1'b0) begin n_fail++; $display("FAIL default_done_width: got %b expected 0", d_done); end
    n_cmp++;
    if (d_wr_cnt !== 1568) begin n_fail++; $display("FAIL default_write_count: got %0d expected 1568", d_wr_cnt); end
    n_cmp++;
    if (d_seq_err !== 0) begin n_fail++; $display("FAIL default_write_order: got %0d out-of-order expected 0", d_seq_err); end
  endtask

  task automatic test_reset_midpass();
    int n0;
    a_wa_q.delete(); a_wd_q.delete();
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (12) @(negedge clk);
    n0 = a_wa_q.size();
    n_cmp++;
    if (a_busy !== 1'b1) begin n_fail++; $display("FAIL midpass_busy: got %b expected 1", a_busy); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_conv_en, a_pool_en, a_pool_we, a_busy, a_done, a_conv_addr, a_pool_addr, a_pool_d} !== 27'b0) begin
      n_fail++; $display("FAIL midpass_reset_outputs: got %h expected 0",
                         {a_conv_en, a_pool_en, a_pool_we, a_busy, a_done, a_conv_addr, a_pool_addr, a_pool_d});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    n_cmp++;
    if (a_wa_q.size() !== n0) begin n_fail++; $display("FAIL midpass_no_write: got %0d writes expected %0d", a_wa_q.size(), n0); end
    n_cmp++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL midpass_waits_idle: got busy %b expected 0", a_busy); end
  endtask

  initial begin
    test_reset();
    test_pattern_a("ramp", 0);
    test_b("neg3", 1'b0);
    test_b("signed", 1'b1);
    test_odd_size();
    test_pattern_a("restart_ignored", 10);
    test_reset_midpass();
    test_pattern_a("rerun", 0);
    test_default_timing();
    n_cmp++;
    if (excl_err !== 0) begin n_fail++; $display("FAIL strobe_exclusion: got %0d violations expected 0", excl_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool2d.md
MAXPOOL2D -- requirements
Module: maxpool2d

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 16, meaning the signed fixed-point sample width.
REQ-002 The block SHALL expose parameter CHANNELS, default 8, meaning the number of feature-map channels in the conv buffer.
REQ-003 The block SHALL expose parameter IMG_SIZE, default 28, meaning the input map height and width.
REQ-004 The block SHALL expose parameter POOL, default 2, meaning the window size and stride; OUT = IMG_SIZE/POOL (integer floor).
REQ-005 The block SHALL have these ports: clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have these ports: reset_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have these ports: start, input, 1, a one-cycle request to begin a pass, sampled only in IDLE.
REQ-008 The block SHALL have these ports: conv_addr, output, $clog2(CHANNELS*IMG_SIZE*IMG_SIZE), the conv buffer read address.
REQ-009 The block SHALL have these ports: conv_en, output, 1, the conv buffer read enable; it is the only read request.
REQ-010 The block SHALL have these ports: conv_q, input, DATA_WIDTH signed, the conv buffer read data, valid exactly one cycle after conv_en.
REQ-011 The block SHALL have these ports: pool_addr, output, $clog2(CHANNELS*OUT*OUT), the pool buffer write address.
REQ-012 The block SHALL have these ports: pool_en and pool_we, output, 1 each, the pool buffer enable and write strobe.
REQ-013 The block SHALL have these ports: pool_d, output, DATA_WIDTH signed, the pool buffer write data.
REQ-014 The block SHALL have these ports: busy, output, 1, high whenever the FSM is not in IDLE.
REQ-015 The block SHALL have these ports: done, output, 1, a one-cycle completion pulse.

Function
REQ-016 The FSM SHALL use the states IDLE, READ, CMP, WRITE and FINISH.
REQ-017 In IDLE, start SHALL clear the c/orow/ocol/kr/kc counters and move the FSM to READ; start outside IDLE SHALL be ignored.
REQ-018 In READ, the block SHALL register conv_addr = (c*IMG_SIZE + orow*POOL+kr)*IMG_SIZE + ocol*POOL+kc, pulse conv_en for one cycle, and move the FSM to CMP.
REQ-019 In CMP, the block SHALL load conv_q into the running max when kr=kc=0, or otherwise replace the max when conv_q is greater under a signed compare.
REQ-020 In CMP, kc SHALL advance first and then kr; after the last window element (kr=kc=POOL-1) the FSM SHALL move to WRITE, otherwise back to READ.
REQ-021 In WRITE, the block SHALL drive pool_addr = (c*OUT + orow)*OUT + ocol, pool_d = the final max, and pool_en = pool_we = 1 for exactly one cycle.
REQ-022 On leaving WRITE, ocol SHALL advance, then orow, then c, each wrapping to 0; after the last pixel the FSM SHALL move to FINISH, otherwise to READ with kr=kc=0.
REQ-023 Each output pixel SHALL take exactly 2*POOL*POOL+1 cycles; done SHALL pulse in FINISH exactly CHANNELS*OUT*OUT*(2*POOL*POOL+1)+1 cycles after the start edge, after which the FSM returns to IDLE.
REQ-024 When IMG_SIZE is odd, the trailing input row and column SHALL never be addressed.
REQ-025 At most one of conv_en or pool_we SHALL be high in any cycle, and the block SHALL never write the conv buffer.
REQ-026 The pooled value SHALL be exactly one of the window samples, with no rounding or rescaling.

Reset
REQ-027 When reset_n=0, the block SHALL asynchronously force state=IDLE, clear all counters and the running max, and drive conv_en, pool_en, pool_we, done and busy to 0 and conv_addr, pool_addr and pool_d to 0.
REQ-028 If reset is asserted mid-pass, the pass SHALL be abandoned with no further writes, and after release the block SHALL wait in IDLE for a new start.

Configuration
REQ-029 When macro MAXPOOL_RELU_EN is defined, pool_d SHALL be max(0, window max); when it is undefined, pool_d SHALL be the raw signed window max, including negative values.

Verification
REQ-030 Test: CHANNELS=1, IMG_SIZE=4, conv[i]=i, start -> pool writes at addresses 0..3 with data 5, 7, 13, 15, in that order.
REQ-031 Test: CHANNELS=2, IMG_SIZE=4, all samples -3 -> pool_d=0xFFFD for all 8 writes without MAXPOOL_RELU_EN, and 0x0000 with it.
REQ-032 Test: default parameters, start -> done high exactly one cycle, 14113 cycles after start; busy high throughout; exactly 1568 writes.
REQ-033 Test: IMG_SIZE=5, CHANNELS=1 -> 4 writes; conv_addr never has row 4 or column 4.
REQ-034 Test: start pulsed again mid-pass -> no restart and an unchanged write sequence; reset_n=0 mid-pass -> outputs 0 the same cycle, no write after, and a clean rerun on the next start.
